// File: rtl/cpu_reg_bank.sv
// cpu_reg_bank: parametrised CPU register file with byte read ports, a 16-bit pair port and a masked flag register.
//   i_clk, i_rst       : clock, synchronous active-high reset
//   i_rd_sel/o_rd_data : NUM_RD packed combinational byte read ports
//   i_wr_en/sel/data   : byte write port
//   i_pair_op/sel/...  : pair LOAD/INC/DEC port, o_pair_data shows the selected pair
//   i_flag_wr_mask/data: per-bit flag update, o_flags shows the flag register
module cpu_reg_bank #(
    parameter int DATA_W         = 8,
    parameter int NUM_REGS       = 8,
    parameter int NUM_RD         = 3,
    parameter int FLAG_IDX       = 6,
    parameter int FLAG_ZERO_BITS = 4,
    parameter int BYPASS         = 0,
    localparam int SEL_W         = $clog2(NUM_REGS),
    localparam int PSEL_W        = (NUM_REGS / 2 > 1) ? $clog2(NUM_REGS / 2) : 1
) (
    input  logic                       i_clk,
    input  logic                       i_rst,
    input  logic [NUM_RD*SEL_W-1:0]    i_rd_sel,
    output logic [NUM_RD*DATA_W-1:0]   o_rd_data,
    input  logic                       i_wr_en,
    input  logic [SEL_W-1:0]           i_wr_sel,
    input  logic [DATA_W-1:0]          i_wr_data,
    input  logic [1:0]                 i_pair_op,
    input  logic [PSEL_W-1:0]          i_pair_sel,
    input  logic [2*DATA_W-1:0]        i_pair_wr_data,
    output logic [2*DATA_W-1:0]        o_pair_data,
    input  logic [DATA_W-1:0]          i_flag_wr_mask,
    input  logic [DATA_W-1:0]          i_flag_wr_data,
    output logic [DATA_W-1:0]          o_flags
);
    localparam logic [DATA_W-1:0] FLAG_KEEP = ~DATA_W'((64'(1) << FLAG_ZERO_BITS) - 64'(1));

    logic [DATA_W-1:0]   regs_q [NUM_REGS];
    logic [DATA_W-1:0]   regs_d [NUM_REGS];
    logic [DATA_W-1:0]   view   [NUM_REGS];
    logic [2*DATA_W-1:0] pair_cur;
    logic [2*DATA_W-1:0] pair_nxt;

    // Out-of-range selects match no register, so their writes vanish and reads stay 0.
    always_comb begin
        pair_cur = '0;
        for (int p = 0; p < NUM_REGS / 2; p++)
            if (i_pair_sel == PSEL_W'(p)) pair_cur = {regs_q[2*p], regs_q[2*p+1]};
        pair_nxt = (i_pair_op == 2'b01) ? i_pair_wr_data :
                   (i_pair_op == 2'b10) ? pair_cur + (2*DATA_W)'(1) :
                                          pair_cur - (2*DATA_W)'(1);
        for (int r = 0; r < NUM_REGS; r++) begin
            regs_d[r] = i_rst ? '0 :
                        (i_pair_op != 2'b00 && i_pair_sel == PSEL_W'(r / 2)) ?
                            ((r % 2 == 0) ? pair_nxt[2*DATA_W-1 -: DATA_W] : pair_nxt[DATA_W-1:0]) :
                        (i_wr_en && i_wr_sel == SEL_W'(r)) ? i_wr_data :
                        (r == FLAG_IDX) ? (regs_q[r] & ~i_flag_wr_mask) | (i_flag_wr_data & i_flag_wr_mask) :
                        regs_q[r];
            // Low flag bits are hard-wired zero whichever path writes them.
            if (r == FLAG_IDX) regs_d[r] = regs_d[r] & FLAG_KEEP;
            // regs_d equals regs_q for unwritten registers, so it doubles as the bypass view.
            view[r] = (BYPASS != 0) ? regs_d[r] : regs_q[r];
        end
    end

    always_comb begin
        o_rd_data   = '0;
        o_pair_data = '0;
        o_flags     = '0;
        for (int k = 0; k < NUM_RD; k++)
            for (int r = 0; r < NUM_REGS; r++)
                if (i_rd_sel[k*SEL_W +: SEL_W] == SEL_W'(r)) o_rd_data[k*DATA_W +: DATA_W] = view[r];
        for (int p = 0; p < NUM_REGS / 2; p++)
            if (i_pair_sel == PSEL_W'(p)) o_pair_data = {view[2*p], view[2*p+1]};
        for (int r = 0; r < NUM_REGS; r++)
            if (r == FLAG_IDX) o_flags = view[r];
    end

    always_ff @(posedge i_clk) begin
        for (int r = 0; r < NUM_REGS; r++) regs_q[r] <= regs_d[r];
    end
endmodule

// File: tb/tb_cpu_reg_bank.sv
// tb_cpu_reg_bank: checks three register-bank variants (default, bypass, 6 registers) against a reference model.
module tb_cpu_reg_bank;
    logic        clk = 0;
    logic        rst = 0;
    logic [8:0]  rd_sel = '0;
    logic        wr_en = 0;
    logic [2:0]  wr_sel = '0;
    logic [7:0]  wr_data = '0;
    logic [1:0]  pair_op = '0;
    logic [1:0]  pair_sel = '0;
    logic [15:0] pair_wd = '0;
    logic [7:0]  fmask = '0;
    logic [7:0]  fdata = '0;
    logic [23:0] rdd [3];
    logic [15:0] pd  [3];
    logic [7:0]  fl  [3];

    int nr [3] = '{8, 8, 6};
    int fi [3] = '{6, 6, 4};
    int bp [3] = '{0, 1, 0};
    logic [7:0] mq [3][8];
    logic [7:0] mn [3][8];
    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    cpu_reg_bank #(.BYPASS(0)) dut0 (
        .i_clk(clk), .i_rst(rst), .i_rd_sel(rd_sel), .o_rd_data(rdd[0]),
        .i_wr_en(wr_en), .i_wr_sel(wr_sel), .i_wr_data(wr_data),
        .i_pair_op(pair_op), .i_pair_sel(pair_sel), .i_pair_wr_data(pair_wd), .o_pair_data(pd[0]),
        .i_flag_wr_mask(fmask), .i_flag_wr_data(fdata), .o_flags(fl[0]));
    cpu_reg_bank #(.BYPASS(1)) dut1 (
        .i_clk(clk), .i_rst(rst), .i_rd_sel(rd_sel), .o_rd_data(rdd[1]),
        .i_wr_en(wr_en), .i_wr_sel(wr_sel), .i_wr_data(wr_data),
        .i_pair_op(pair_op), .i_pair_sel(pair_sel), .i_pair_wr_data(pair_wd), .o_pair_data(pd[1]),
        .i_flag_wr_mask(fmask), .i_flag_wr_data(fdata), .o_flags(fl[1]));
    cpu_reg_bank #(.NUM_REGS(6), .FLAG_IDX(4)) dut2 (
        .i_clk(clk), .i_rst(rst), .i_rd_sel(rd_sel), .o_rd_data(rdd[2]),
        .i_wr_en(wr_en), .i_wr_sel(wr_sel), .i_wr_data(wr_data),
        .i_pair_op(pair_op), .i_pair_sel(pair_sel), .i_pair_wr_data(pair_wd), .o_pair_data(pd[2]),
        .i_flag_wr_mask(fmask), .i_flag_wr_data(fdata), .o_flags(fl[2]));

    task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Next state: lay down each source lowest priority first so higher ones overwrite it.
    task automatic compute(input int c);
        logic [15:0] v;
        for (int r = 0; r < 8; r++) mn[c][r] = rst ? 8'h00 : mq[c][r];
        if (!rst) begin
            mn[c][fi[c]] = (mq[c][fi[c]] & ~fmask) | (fdata & fmask);
            if (wr_en && int'(wr_sel) < nr[c]) mn[c][wr_sel] = wr_data;
            if (pair_op != 2'b00 && int'(pair_sel) < nr[c] / 2) begin
                v = {mq[c][2*pair_sel], mq[c][2*pair_sel+1]};
                case (pair_op)
                    2'b01:   v = pair_wd;
                    2'b10:   v = v + 16'd1;
                    default: v = v - 16'd1;
                endcase
                mn[c][2*pair_sel]   = v[15:8];
                mn[c][2*pair_sel+1] = v[7:0];
            end
            mn[c][fi[c]] = mn[c][fi[c]] & 8'hF0;
        end
    endtask

    function automatic logic [7:0] vw(input int c, input int r);
        return (r >= nr[c]) ? 8'h00 : (bp[c] != 0) ? mn[c][r] : mq[c][r];
    endfunction

    task automatic step();
        int s;
        @(negedge clk);
        for (int c = 0; c < 3; c++) begin
            compute(c);
            for (int k = 0; k < 3; k++) begin
                s = int'(rd_sel[k*3 +: 3]);
                chk($sformatf("dut%0d_rd%0d", c, k), 16'(rdd[c][k*8 +: 8]), 16'(vw(c, s)));
            end
            s = int'(pair_sel);
            chk($sformatf("dut%0d_pair", c), pd[c], (s < nr[c] / 2) ? {vw(c, 2*s), vw(c, 2*s+1)} : 16'h0000);
            chk($sformatf("dut%0d_flags", c), 16'(fl[c]), 16'(vw(c, fi[c])));
        end
        @(posedge clk);
        #1;
        mq = mn;
    endtask

    task automatic idle();
        rst = 0; wr_en = 0; pair_op = 2'b00; fmask = 8'h00;
    endtask

    initial begin
        rst = 1;
        repeat (2) @(posedge clk);
        #1;
        for (int c = 0; c < 3; c++) for (int r = 0; r < 8; r++) mq[c][r] = 8'h00;
        idle();
        for (int r = 0; r < 8; r++) begin
            wr_en = 1; wr_sel = 3'(r); wr_data = 8'hAA; step();
        end
        rst = 1; wr_en = 1; wr_sel = 3'd1; wr_data = 8'h55; pair_op = 2'b01; pair_sel = 2'd0; pair_wd = 16'h7777;
        step();
        idle(); rd_sel = {3'd2, 3'd1, 3'd0}; pair_sel = 2'd0; #1;
        chk("reset_rd", 16'(rdd[0]), 16'h0000);
        chk("reset_pair", pd[0], 16'h0000);
        chk("reset_flags", 16'(fl[0]), 16'h0000);
        wr_en = 1; wr_sel = 3'd2; wr_data = 8'h5C; rd_sel = {3'd0, 3'd1, 3'd2}; #1;
        chk("bypass_same_cycle", 16'(rdd[1][7:0]), 16'h005C);
        chk("nobypass_old", 16'(rdd[0][7:0]), 16'h0000);
        step(); idle(); #1;
        chk("wr_latency", 16'(rdd[0][7:0]), 16'h005C);
        pair_op = 2'b01; pair_sel = 2'd2; pair_wd = 16'hFFFF; step();
        pair_op = 2'b10; step(); idle(); #1;
        chk("pair_inc_wrap", pd[0], 16'h0000);
        pair_op = 2'b11; step(); idle(); #1;
        chk("pair_dec_wrap", pd[0], 16'hFFFF);
        pair_op = 2'b01; pair_wd = 16'h1234; rd_sel = {3'd0, 3'd5, 3'd4}; step(); idle(); #1;
        chk("pair_load_hi", 16'(rdd[0][7:0]), 16'h0012);
        chk("pair_load_lo", 16'(rdd[0][15:8]), 16'h0034);
        pair_op = 2'b01; pair_wd = 16'hBEEF; wr_en = 1; wr_sel = 3'd5; wr_data = 8'h11; step(); idle(); #1;
        chk("collide_pair", pd[0], 16'hBEEF);
        pair_op = 2'b01; pair_wd = 16'hCAFE; wr_en = 1; wr_sel = 3'd3; wr_data = 8'h11; rd_sel = {3'd0, 3'd0, 3'd3};
        step(); idle(); #1;
        chk("nocollide_byte", 16'(rdd[0][7:0]), 16'h0011);
        chk("nocollide_pair", pd[0], 16'hCAFE);
        wr_en = 1; wr_sel = 3'd6; wr_data = 8'hFF; step(); idle(); #1;
        chk("flag_byte", 16'(fl[0]), 16'h00F0);
        fmask = 8'h80; fdata = 8'h00; step(); idle(); #1;
        chk("flag_mask", 16'(fl[0]), 16'h0070);
        wr_en = 1; wr_sel = 3'd6; wr_data = 8'h30; fmask = 8'hFF; fdata = 8'hC0; step(); idle(); #1;
        chk("flag_byte_wins", 16'(fl[0]), 16'h0030);
        pair_op = 2'b01; pair_sel = 2'd3; pair_wd = 16'hABCD; rd_sel = {3'd0, 3'd0, 3'd7}; step(); idle(); #1;
        chk("flag_pair", 16'(fl[0]), 16'h00A0);
        chk("pair3_lo", 16'(rdd[0][7:0]), 16'h00CD);
        chk("oor_rd", 16'(rdd[2][7:0]), 16'h0000);
        wr_en = 1; wr_sel = 3'd7; wr_data = 8'h99; step(); idle();
        pair_op = 2'b10; pair_sel = 2'd3; step(); idle();
        for (int i = 0; i < 400; i++) begin
            rst      = ($urandom_range(0, 24) == 0);
            wr_en    = 1'($urandom);
            wr_sel   = 3'($urandom);
            wr_data  = 8'($urandom);
            pair_op  = 2'($urandom);
            pair_sel = 2'($urandom);
            pair_wd  = ($urandom_range(0, 3) == 0) ? (($urandom_range(0, 1) == 0) ? 16'hFFFF : 16'h0000) : 16'($urandom);
            fmask    = ($urandom_range(0, 1) == 0) ? 8'h00 : 8'($urandom);
            fdata    = 8'($urandom);
            rd_sel   = 9'($urandom);
            step();
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/cpu_reg_bank.md
Name: cpu_reg_bank

Overview:
- Parametrised successor to the CPU's 8-register file.
- Adds:
  - N configurable combinational read ports.
  - 16-bit pair port for any register pair, with LOAD/INC/DEC.
  - Masked flag-register update with hard-wired zero low bits.
  - Optional write-to-read bypass.
- Sits between the decoder/ALU and the datapath muxes; supplies operands, HL/SP-style pointers and flags in one block.

Parameters:
- DATA_W, 8, register width in bits.
- NUM_REGS, 8, register count; even, ≥2; pair p = {reg[2p], reg[2p+1]} (high, low).
- NUM_RD, 3, number of byte read ports.
- FLAG_IDX, 6, index of the flag register.
- FLAG_ZERO_BITS, 4, low bits of the flag register that always read/store 0.
- BYPASS, 0, 1 = reads return the value being written this cycle.
- Derived:
  - SEL_W = clog2(NUM_REGS).
  - PSEL_W = max(1, clog2(NUM_REGS/2)).

Ports:
- i_clk  in  1  clock, rising edge.
- i_rst  in  1  synchronous, active-high reset.
- i_rd_sel  in  NUM_RD*SEL_W  packed read selects; port k at bits [k*SEL_W +: SEL_W].
- o_rd_data  out  NUM_RD*DATA_W  packed read data; port k at bits [k*DATA_W +: DATA_W].
- i_wr_en  in  1  byte write enable.
- i_wr_sel  in  SEL_W  byte write target.
- i_wr_data  in  DATA_W  byte write data.
- i_pair_op  in  2  pair operation: 00 none, 01 LOAD, 10 INC, 11 DEC.
- i_pair_sel  in  PSEL_W  pair index.
- i_pair_wr_data  in  2*DATA_W  LOAD data, high byte to reg[2p].
- o_pair_data  out  2*DATA_W  current value of pair i_pair_sel.
- i_flag_wr_mask  in  DATA_W  per-bit flag update enable.
- i_flag_wr_data  in  DATA_W  flag update data.
- o_flags  out  DATA_W  current flag register.

Behaviour:
- One clock domain, i_clk. Reset is synchronous and active-high, on i_rst.
- Reset:
  - On a rising edge with i_rst=1, all registers become 0 and every other write this cycle is discarded.
  - All outputs read 0 on the following cycle.
- Reads are combinational from register state.
- Out-of-range selects (index ≥ NUM_REGS or pair ≥ NUM_REGS/2):
  - Reads return 0.
  - Writes are ignored.
- Pair ops update the pair at the next edge:
  - LOAD: pair <= i_pair_wr_data.
  - INC: pair <= pair+1, modulo 2^(2*DATA_W); 16'hFFFF -> 16'h0000.
  - DEC: pair <= pair-1, modulo 2^(2*DATA_W); 16'h0000 -> 16'hFFFF.
  - INC/DEC never touch flags.
- Flag masked write: for each bit i with mask[i]=1, flag[i] <= i_flag_wr_data[i]; other bits hold.
- Per-register write priority within one cycle, highest first:
  1. Reset.
  2. Pair op covering the register.
  3. Byte write.
  4. Flag masked write (FLAG_IDX only).
  5. Hold.
- A byte write that collides with an active pair op on either pair register is dropped for that register only. Non-colliding writes from both sources commit in the same cycle.
- Flag register:
  - Bits [FLAG_ZERO_BITS-1:0] are forced 0 on every write path: pair, byte and masked.
  - They read 0 at all times.
- BYPASS=0:
  - Any write becomes visible on o_rd_data, o_pair_data and o_flags the cycle after the edge.
- BYPASS=1:
  - Reads return the computed next-state value, after the priority and zero-bit rules, whenever that register is written this cycle. Otherwise they return current state.
  - With i_rst=1, bypassed reads return 0.
- No internal state besides the NUM_REGS registers. No stalls, no handshake; every request completes in one cycle.

Test Plan:
- Reset then read: write 0xAA to all regs, assert i_rst one cycle -> all o_rd_data, o_pair_data, o_flags = 0 next cycle; a concurrent byte write in the reset cycle is not committed.
- Byte write/read latency, BYPASS=0: write reg2=0x5C -> rd port0 (sel 2) shows old value in the same cycle and 0x5C after the edge. With BYPASS=1, 0x5C appears in the same cycle.
- Pair wrap: LOAD pair2 = 0xFFFF; next cycle INC -> reg4=0x00, reg5=0x00. Then DEC -> 0xFFFF. Then LOAD 0x1234 -> reg4=0x12, reg5=0x34.
- Collision: same cycle LOAD pair2=0xBEEF, byte write reg5=0x11, byte...no, byte write reg5=0x11 only -> reg4=0xBE, reg5=0xEF. Repeat with the byte write to reg3=0x11 -> reg3=0x11 and the pair commits as well.
- Flags:
  - Byte write reg6=0xFF -> o_flags=0xF0.
  - Then mask 0x80, data 0x00 -> 0x70.
  - Byte write 0x30 plus mask 0xFF, data 0xC0 in the same cycle -> 0x30 (byte write wins).
  - LOAD pair3=0xABCD -> reg6=0xA0, reg7=0xCD.
- Out-of-range, NUM_REGS=6: read sel 7 -> 0; write sel 7=0x99 -> no register changes; pair op on pair 3 -> no register changes.
